// File: rtl/score_pkg.sv
// Shared definitions for the scoreboard serial report path.
package score_pkg;

  localparam logic [7:0]  PKT_HDR = 8'hA5;
  localparam int unsigned PKT_LEN = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } pkt_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter, LSB first. A start request on the last cycle of a
// stop bit chains the next byte with no idle gap.
module uart_byte_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] byte_data,
  input  logic       start,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned     CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          active_q, active_d;
  logic          tx_q, tx_d;

  assign byte_done = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);
  assign tx        = tx_q;

  // Bit/baud sequencing: bit 0 = start, 1..8 = data, 9 = stop.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    tx_d     = tx_q;
    if (start && (!active_q || byte_done)) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = byte_data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          bit_d    = '0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
  end

  // Transmitter state; line idles high out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/score_report_tx.sv
// Snapshots the match state and sends it as a 5-byte UART packet:
// header, {team_sel, period}, score_a, score_b, xor checksum.
module score_report_tx
  import score_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       send,
  input  logic [7:0] score_a,
  input  logic [7:0] score_b,
  input  logic [1:0] period,
  input  logic       team_sel,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  pkt_state_e state_q, state_d;
  logic       pending_q, pending_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] b1_q, b1_d, sa_q, sa_d, sb_q, sb_d, chk_q, chk_d;
  logic       byte_start, byte_done;
  logic [7:0] byte_data, next_byte;

  assign busy = (state_q != IDLE) | pending_q;
  assign done = (state_q == DONE);

  // Byte following the one currently on the line.
  always_comb begin
    case (idx_q)
      3'd0:    next_byte = b1_q;
      3'd1:    next_byte = sa_q;
      3'd2:    next_byte = sb_q;
      default: next_byte = chk_q;
    endcase
  end

  // Packet FSM, snapshot capture and request tracking.
  // A send seen in IDLE is parked in pending and consumed on the next cycle,
  // so IDLE and DONE share the same pending->LOAD path; the header byte is
  // handed to the transmitter during LOAD, giving the 2-cycle packet gap.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | send;
    idx_d      = idx_q;
    b1_d       = b1_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    chk_d      = chk_q;
    byte_start = 1'b0;
    byte_data  = PKT_HDR;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = LOAD;
          pending_d = send;
        end
      end
      LOAD: begin
        b1_d       = {5'b0, team_sel, period};
        sa_d       = score_a;
        sb_d       = score_b;
        chk_d      = PKT_HDR ^ {5'b0, team_sel, period} ^ score_a ^ score_b;
        idx_d      = '0;
        byte_start = 1'b1;
        byte_data  = PKT_HDR;
        state_d    = SEND;
      end
      SEND: begin
        if (byte_done) begin
          if (idx_q == 3'(PKT_LEN - 1)) begin
            state_d = DONE;
          end else begin
            idx_d      = idx_q + 3'd1;
            byte_start = 1'b1;
            byte_data  = next_byte;
          end
        end
      end
      DONE: begin
        if (pending_q) begin
          state_d   = LOAD;
          pending_d = send;
        end else if (send) begin
          state_d   = LOAD;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      idx_q     <= '0;
      b1_q      <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      b1_q      <= b1_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      chk_q     <= chk_d;
    end
  end

  uart_byte_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte_tx (
    .clk      (clk),
    .rstn     (rstn),
    .byte_data(byte_data),
    .start    (byte_start),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_score_report_tx.sv
// Directed bench for score_report_tx with BAUD_DIV = 4.
module tb_score_report_tx;

  logic       clk, rstn, send, team_sel, tx, busy, done;
  logic [7:0] score_a, score_b;
  logic [1:0] period;

  int n_chk  = 0;
  int n_pass = 0;
  int ncyc   = 0;
  int done_cnt = 0;
  int done_at  = 0;
  int frame_err;
  int pkt_start;
  logic [7:0] rx [0:4];

  score_report_tx #(.BAUD_DIV(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .send    (send),
    .score_a (score_a),
    .score_b (score_b),
    .period  (period),
    .team_sel(team_sel),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_at  <= ncyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Called at a negedge; s = cycle count at which send was raised.
  task automatic send_pulse(output int s);
    send = 1'b1;
    s = ncyc;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b, output int sc);
    int n;
    n = 0;
    b = '0;
    sc = ncyc;
    while (tx !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check("rx_start_timeout", 32'(tx), 32'd0);
      return;
    end
    sc = ncyc;
    repeat (2) @(negedge clk);
    if (tx !== 1'b0) frame_err++;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b1) frame_err++;
  endtask

  task automatic recv_packet();
    int sc;
    frame_err = 0;
    for (int k = 0; k < 5; k++) begin
      recv_byte(rx[k], sc);
      if (k == 0) pkt_start = sc;
    end
  endtask

  task automatic expect_pkt(input string tag, input logic [39:0] e);
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_b%0d", tag, k), 32'(rx[k]), 32'(e[39-8*k -: 8]));
    check({tag, "_frame"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int s, t, p1s, dc0, lows;
    rstn = 1'b0; send = 1'b0; score_a = '0; score_b = '0; period = '0; team_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;

    // Idle for 100 cycles
    repeat (100) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done_cnt", 32'(done_cnt), 32'd0);

    // Single packet: 12/7, period 2, team B
    score_a = 8'd12; score_b = 8'd7; period = 2'd2; team_sel = 1'b1;
    send_pulse(s);
    check("p1_busy_rise", 32'(busy), 32'd1);
    recv_packet();
    expect_pkt("p1", 40'hA5_06_0C_07_A8);
    check("p1_latency", 32'(pkt_start - s), 32'd3);
    repeat (4) @(negedge clk);
    check("p1_done_gap", 32'(done_at - pkt_start), 32'd200);
    check("p1_done_cnt", 32'(done_cnt), 32'd1);
    check("p1_busy_end", 32'(busy), 32'd0);

    // Input change during B1 must not leak into the packet
    send_pulse(s);
    fork
      recv_packet();
      begin
        repeat (60) @(negedge clk);
        score_a = 8'd99;
      end
    join
    expect_pkt("p2", 40'hA5_06_0C_07_A8);
    repeat (4) @(negedge clk);

    // Three sends during one packet -> exactly one follow-up packet with fresh data
    score_a = 8'h01; score_b = 8'h02; period = 2'd1; team_sel = 1'b0;
    dc0 = done_cnt;
    send_pulse(s);
    fork
      begin
        recv_packet();
        expect_pkt("p3a", 40'hA5_01_01_02_A7);
        p1s = pkt_start;
        recv_packet();
        expect_pkt("p3b", 40'hA5_04_33_44_D6);
        check("p3_gap", 32'(pkt_start - p1s), 32'd202);
      end
      begin
        repeat (30) @(negedge clk);
        send_pulse(t);
        repeat (30) @(negedge clk);
        send_pulse(t);
        repeat (30) @(negedge clk);
        send_pulse(t);
        repeat (20) @(negedge clk);
        score_a = 8'h33; score_b = 8'h44; period = 2'd0; team_sel = 1'b1;
      end
    join
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("p3_no_third", 32'(lows), 32'd0);
    check("p3_done_cnt", 32'(done_cnt - dc0), 32'd2);
    check("p3_busy_end", 32'(busy), 32'd0);

    // Reset during the B2 start bit aborts the packet
    dc0 = done_cnt;
    send_pulse(s);
    repeat (s + 84 - ncyc) @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx), 32'd0);
    #2 rstn = 1'b0;
    #1 check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (250) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt - dc0), 32'd0);

    // Edge values after reset
    score_a = 8'hFF; score_b = 8'h00; period = 2'd3; team_sel = 1'b0;
    send_pulse(s);
    recv_packet();
    expect_pkt("p4", 40'hA5_03_FF_00_59);
    check("p4_latency", 32'(pkt_start - s), 32'd3);
    repeat (4) @(negedge clk);
    check("p4_done_cnt", 32'(done_cnt - dc0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
